// File: rtl/lockin_acumulador.sv
// Dual-phase lock-in demodulator with block accumulator (one ADS1299 channel).
// Optional macro LOCKIN_ALINEACION_EN aligns blocks to ref_inicio.
module lockin_acumulador #(
    parameter int Q_adc = 24,
    parameter int Q_ref = 16,
    parameter int Q_out = 64,
    parameter int M     = 16,
    parameter int N     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    habilitar,
    input  logic signed [Q_adc-1:0] data_in,
    input  logic                    data_in_valid,
    input  logic        [Q_ref-1:0] ref_fase,
    input  logic        [Q_ref-1:0] ref_cuad,
    input  logic                    ref_inicio,
    output logic signed [Q_out-1:0] data_out_fase,
    output logic signed [Q_out-1:0] data_out_cuad,
    output logic                    data_out_valid,
    output logic        [15:0]      bloques_completos
);

    localparam int MN = M * N;
    localparam int CW = (MN > 1) ? $clog2(MN) : 1;
    localparam int PW = Q_adc + Q_ref + 1;
    localparam logic [CW-1:0] ULTIMO = CW'(MN - 1);
    localparam logic signed [Q_ref:0] OFFSET = {2'b01, {(Q_ref-1){1'b0}}};

    typedef enum logic {IDLE, ACUM} estado_t;

    estado_t estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pos;
    logic tomar, reinicio, es_ultimo;

    logic                    s1_valid, s1_ult;
    logic signed [Q_adc-1:0] s1_dato;
    logic signed [Q_ref:0]   s1_rf, s1_rc;

    logic                    s2_valid, s2_ult;
    logic signed [PW-1:0]    s2_pf, s2_pc;

    logic signed [Q_out-1:0] acc_f, acc_c;
    logic signed [Q_out-1:0] pf_ext, pc_ext;

    assign pf_ext = {{(Q_out-PW){s2_pf[PW-1]}}, s2_pf};
    assign pc_ext = {{(Q_out-PW){s2_pc[PW-1]}}, s2_pc};

    // Sample acceptance, block position and next state
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        pos       = cnt_q;
        tomar     = 1'b0;
        reinicio  = 1'b0;
        es_ultimo = 1'b0;
        if (!habilitar) begin
            estado_d = IDLE;
            cnt_d    = '0;
        end else if (data_in_valid) begin
            unique case (estado_q)
                IDLE: begin
`ifdef LOCKIN_ALINEACION_EN
                    tomar = ref_inicio;
`else
                    tomar = 1'b1;
`endif
                end
                ACUM: begin
                    tomar = 1'b1;
`ifdef LOCKIN_ALINEACION_EN
                    reinicio = ref_inicio && ((32'(cnt_q) % N) != 0);
`else
                    // ref_inicio has no effect without alignment
                    reinicio = ref_inicio && 1'b0;
`endif
                end
                default: ;
            endcase
            if (tomar) begin
                estado_d  = ACUM;
                pos       = (reinicio || estado_q == IDLE) ? '0 : cnt_q;
                es_ultimo = (pos == ULTIMO);
                cnt_d     = es_ultimo ? '0 : pos + 1'b1;
            end
        end
    end

    // State and sample counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stage 1: capture sample and remove reference offset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ult   <= 1'b0;
            s1_dato  <= '0;
            s1_rf    <= '0;
            s1_rc    <= '0;
        end else if (!habilitar) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= tomar;
            if (tomar) begin
                s1_ult  <= es_ultimo;
                s1_dato <= data_in;
                s1_rf   <= $signed({1'b0, ref_fase}) - OFFSET;
                s1_rc   <= $signed({1'b0, ref_cuad}) - OFFSET;
            end
        end
    end

    // Stage 2: multiply; a restart drops partial-block products only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_ult   <= 1'b0;
            s2_pf    <= '0;
            s2_pc    <= '0;
        end else if (!habilitar) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid && (!reinicio || s1_ult);
            if (s1_valid) begin
                s2_ult <= s1_ult;
                s2_pf  <= PW'(s1_dato) * PW'(s1_rf);
                s2_pc  <= PW'(s1_dato) * PW'(s1_rc);
            end
        end
    end

    // Stage 3: accumulate and emit the block result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_f             <= '0;
            acc_c             <= '0;
            data_out_fase     <= '0;
            data_out_cuad     <= '0;
            data_out_valid    <= 1'b0;
            bloques_completos <= '0;
        end else begin
            data_out_valid <= 1'b0;
            if (!habilitar) begin
                acc_f <= '0;
                acc_c <= '0;
            end else if (s2_valid && s2_ult) begin
                data_out_fase     <= acc_f + pf_ext;
                data_out_cuad     <= acc_c + pc_ext;
                acc_f             <= '0;
                acc_c             <= '0;
                data_out_valid    <= 1'b1;
                bloques_completos <= bloques_completos + 16'd1;
            end else if (reinicio) begin
                acc_f <= '0;
                acc_c <= '0;
            end else if (s2_valid) begin
                acc_f <= acc_f + pf_ext;
                acc_c <= acc_c + pc_ext;
            end
        end
    end

endmodule

// File: doc/lockin_acumulador.md
# lockin_acumulador

Dual-phase lock-in demodulator and block accumulator for one ADS1299 channel. It multiplies each ADC sample by the in-phase and quadrature reference samples that arrive with it, and accumulates the products over M periods of N samples each. It then emits one signed in-phase/quadrature pair with a one-cycle valid pulse. It sits directly upstream of the amplitude stage (R² = X² + Y², sqrt, scale by M·N·ref_mean/2) and drives that stage's data_in_fase, data_in_cuad and data_in_valid.

## Interface
- Q_adc, 24: signed ADC sample width.
- Q_ref, 16: unsigned offset-binary reference width; mean value 2^(Q_ref-1).
- Q_out, 64: output width; must be ≥ Q_adc+Q_ref+1+clog2(M·N).
- M, 16: periods per block.
- N, 8: samples per reference period.

- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- habilitar  in  1  accumulation enable; low aborts the current block.
- data_in  in  Q_adc  signed ADC sample.
- data_in_valid  in  1  sample strobe; may be high on consecutive cycles.
- ref_fase  in  Q_ref  unsigned in-phase reference, aligned with data_in.
- ref_cuad  in  Q_ref  unsigned quadrature reference, aligned with data_in.
- ref_inicio  in  1  high with the sample at reference index 0.
- data_out_fase  out  Q_out  signed accumulated X.
- data_out_cuad  out  Q_out  signed accumulated Y.
- data_out_valid  out  1  one-cycle pulse; outputs are stable until the next pulse.
- bloques_completos  out  16  count of emitted blocks, wraps at 2^16.

## Operation
- Stage 1 (register): on data_in_valid && habilitar, capture data_in. Capture r_f = {0,ref_fase} − 2^(Q_ref-1) and r_c likewise (Q_ref+1 bits, signed).
- Stage 2 (multiply): p_f = data_in·r_f, p_c = data_in·r_c. Signed, Q_adc+Q_ref+1 bits, sign-extended to Q_out.
- Stage 3 (accumulate): acc += p. On the product of sample M·N−1:
  - copy acc+p to data_out_*;
  - load acc with 0;
  - pulse data_out_valid;
  - increment bloques_completos.
- No sample is dropped between blocks. The first sample of the next block may be in stage 2 while the current block's result is being emitted.
- Sample counter: 0..M·N−1. It advances only on accepted samples and wraps to 0 on block completion.
- States:
  - IDLE → ACUM on the first accepted sample (subject to the alignment rule under Configuration).
  - ACUM → ACUM on block completion.
  - ACUM → IDLE when habilitar is low.
- habilitar low: flush the pipeline, clear acc and the counter, and go to IDLE. A product in flight is discarded and no pulse is generated. data_out_* and bloques_completos are held.
- Reset (any time, including mid-block) sets:
  - state IDLE;
  - acc, counter, all pipeline valids: 0;
  - data_out_fase, data_out_cuad: 0;
  - data_out_valid: 0;
  - bloques_completos: 0.
- Overflow is not possible within the Q_out constraint. Arithmetic wraps if the constraint is violated; the implementation must not saturate.

## Timing
- Latency: data_out_valid rises exactly 3 clk cycles after the cycle in which sample M·N−1 is accepted.
- Throughput: one sample per cycle, sustained indefinitely.
- Gaps in data_in_valid stall counting only. Products already in flight complete.
- data_out_valid is never high on two consecutive cycles when M·N ≥ 2.
- Downstream consumer rules:
  - It may latch the outputs on the pulse cycle or at any time before the next pulse.
  - The minimum spacing between pulses is M·N cycles.

## Configuration
- LOCKIN_ALINEACION_EN defined:
  - IDLE → ACUM only on a sample accepted with ref_inicio=1; that sample is sample 0. Samples before it are ignored.
  - In ACUM, ref_inicio=1 on a sample whose counter mod N ≠ 0 discards the partial block and restarts with that sample as sample 0. No pulse is generated.
- LOCKIN_ALINEACION_EN undefined: ref_inicio is ignored, and the first accepted sample after reset or after habilitar rises is sample 0.

## Test plan
- Constant input (habilitar=1, 128 back-to-back samples):
  - Stimulus: data_in=1000, ref_fase=40000, ref_cuad=32768.
  - Response: data_out_fase=925696000, data_out_cuad=0, a single pulse 3 cycles after the last sample, bloques_completos=1.
- Negative operand, same sample count:
  - Stimulus: data_in=−5, ref_fase=0, ref_cuad=65535.
  - Response: data_out_fase=20971520, data_out_cuad=−20970880.
- Gapped input: the constant case with data_in_valid high 1 cycle in 4 → identical result; pulse 3 cycles after the 128th valid.
- Abort mid-block:
  - Stimulus: 256 constant samples; habilitar low for 1 cycle after sample 70.
  - Response: the first result corresponds to samples 71–198 only; no pulse around the drop.
- Reset mid-block: assert reset after 50 samples → all outputs 0 immediately (asynchronous). The next 128 samples yield the full constant-case result.
- Alignment (macro defined):
  - Stimulus: 5 samples with ref_inicio=0, then ref_inicio on every 8th sample; later a spurious ref_inicio at counter=13.
  - Response: the first 5 samples are ignored; the spurious ref_inicio restarts the block with no pulse. With the macro undefined, the same stimulus gives a pulse after sample 128 counted from the first sample.
